fifo_rd_fwft: RTL and testbench
===============================

# fifo_rd_fwft

Read-side output stage of the asynchronous dual-clock FIFO, in the r_clk domain directly downstream of the read-pointer/empty logic and the dual-port RAM read port. It issues pops to the pointer block, captures the synchronously-read RAM word, and presents it on a first-word-fall-through valid/ready stream through a 2-entry buffer (head + skid). It sustains one word per cycle with no bubbles and never drops or duplicates a word.

## Interface
- DATA_WIDTH, 8, width of a FIFO word.
- ADDR_WIDTH, 4, FIFO address width; depth is 2^ADDR_WIDTH.
- r_clk  in  1  read-domain clock.
- r_rstn  in  1  asynchronous, active-low reset.
- fifo_empty  in  1  high when the FIFO has no word to pop this cycle.
- fifo_rdata  in  DATA_WIDTH  RAM read data; holds the popped word in the cycle after a pop.
- fifo_ren  out  1  pop request to the pointer block; a pop occurs when fifo_ren=1 and fifo_empty=0.
- m_valid  out  1  m_data holds a valid word.
- m_ready  in  1  downstream accepts the word when m_valid=1.
- m_data  out  DATA_WIDTH  head word.
- With FIFO_RD_LEVEL_EN only: rq2_wptr in ADDR_WIDTH+1 (synchronized Gray write pointer), rptr_gray in ADDR_WIDTH+1 (registered Gray read pointer), r_level out ADDR_WIDTH+2 (words available to the reader).

## Operation
- State: head register (valid + data), skid register (valid + data), inflight flag (pop issued last cycle), occ = head_v + skid_v.
- fifo_ren = ~fifo_empty & ((occ + inflight < 2) | (m_valid & m_ready)). Combinational path from m_ready to fifo_ren is intentional.
- inflight <= fifo_ren & ~fifo_empty.
- Accept: m_valid = head_v; a transfer occurs when m_valid & m_ready.
- Write-back of an arriving word (inflight=1), by case:
  - Head empty, or head accepted with skid empty: word goes to the head.
  - Head accepted with skid full: skid moves to head, word goes to skid.
  - Head held (m_ready=0, or head full and not accepted): word goes to the skid.
- No arrival and head accepted: skid, if valid, moves to head, else head_v clears.
- Invariant: occ + inflight ≤ 2 every cycle, so an arriving word always has a free slot. Overflow of the skid is a design error; the bench asserts it never occurs.
- m_data is stable while m_valid=1 and m_ready=0. Words leave in pop order.

## Timing
- Reset values: fifo_ren=0 (fifo_empty=1 on reset), m_valid=0, m_data=0, head/skid/inflight=0, r_level=0.
- Reset mid-operation clears all state asynchronously. An in-flight word is discarded; the pointer block resets on the same r_rstn.
- Latency: fifo_empty falls in cycle N, fifo_ren=1 in N, word on fifo_rdata in N+1, m_valid=1 in N+2.
- Throughput: with m_ready held high and the FIFO non-empty, one word per cycle after the initial 2-cycle latency.
- Backpressure: m_ready low for ≥2 cycles fills head and skid, then fifo_ren=0. When m_ready returns, fifo_ren=1 in that same cycle.
- Simultaneous arrival, accept and new pop in one cycle is legal and loses no word.

## Configuration
- FIFO_RD_LEVEL_EN defined:
  - Adds rq2_wptr, rptr_gray and r_level.
  - Both Gray pointers are converted to binary; the difference is taken modulo 2^(ADDR_WIDTH+1).
  - r_level <= difference + occ + inflight, registered, range 0..2^ADDR_WIDTH+2. It wraps correctly across the pointer MSB.
- FIFO_RD_LEVEL_EN undefined: these ports and their logic are absent; behaviour is otherwise identical.

## Test plan
- Reset: assert r_rstn low mid-stream with head and skid full -> m_valid=0, m_data=0, fifo_ren=0 immediately; no stale word appears after release.
- Single word: fifo_empty low for one pop of 0xA5 -> m_valid=1 two cycles later with m_data=0xA5, then m_valid=0 after accept.
- Streaming: 16 words 0x00..0x0F with m_ready=1 -> 16 consecutive m_valid cycles, in order, no bubbles.
- Backpressure: m_ready=0 for 5 cycles mid-stream -> fifo_ren drops after 2 words are buffered, m_data holds; on release the sequence continues with no gaps, drops or duplicates.
- Random: random fifo_empty and m_ready for 10,000 cycles -> output sequence equals pop sequence; occ + inflight never exceeds 2.
- FIFO_RD_LEVEL_EN: write pointer 3 ahead of a wrapped read pointer (rptr bin 30, wptr bin 1, ADDR_WIDTH=4) with empty buffer -> r_level=3.

Source files
------------

// File: rtl/fifo_rd_fwft.sv
//-----------------------------------------------------------------------------
// fifo_rd_fwft
//
// Read-side output stage of the dual-clock FIFO (r_clk domain). It issues
// pops to the read-pointer block and captures the RAM word one cycle later.
// The word is then presented as a first-word-fall-through valid/ready stream
// through a two-entry buffer (head + skid). The stage sustains one word per
// cycle, with no bubbles, drops or duplicates.
//
// Parameters
//   DATA_WIDTH  width of a FIFO word
//   ADDR_WIDTH  FIFO address width (depth 2^ADDR_WIDTH). This parameter
//               exists only when FIFO_RD_LEVEL_EN is defined, because
//               nothing else in the stage depends on the FIFO depth.
//
// Ports
//   r_clk       read-domain clock
//   r_rstn      asynchronous active-low reset
//   fifo_empty  FIFO has no word to pop this cycle
//   fifo_rdata  RAM read data, valid in the cycle after a pop
//   fifo_ren    pop request; a pop happens when fifo_ren & ~fifo_empty
//   m_valid     m_data holds a valid word (registered)
//   m_ready     downstream accepts the word when m_valid is high
//   m_data      head word (registered)
//
// Optional feature (macro FIFO_RD_LEVEL_EN)
//   rq2_wptr    synchronized Gray write pointer
//   rptr_gray   registered Gray read pointer
//   r_level     registered count of words available to the reader,
//               including the words held or in flight in this stage
//-----------------------------------------------------------------------------
module fifo_rd_fwft #(
   parameter int DATA_WIDTH = 8
`ifdef FIFO_RD_LEVEL_EN
  ,parameter int ADDR_WIDTH = 4
`endif
) (
   input  logic                  r_clk,
   input  logic                  r_rstn,
   input  logic                  fifo_empty,
   input  logic [DATA_WIDTH-1:0] fifo_rdata,
   output logic                  fifo_ren,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [DATA_WIDTH-1:0] m_data
`ifdef FIFO_RD_LEVEL_EN
  ,input  logic [ADDR_WIDTH:0]   rq2_wptr,
   input  logic [ADDR_WIDTH:0]   rptr_gray,
   output logic [ADDR_WIDTH+1:0] r_level
`endif
);

   logic                  head_v_r, head_v_n_s;
   logic [DATA_WIDTH-1:0] head_d_r, head_d_n_s;
   logic                  skid_v_r, skid_v_n_s;
   logic [DATA_WIDTH-1:0] skid_d_r, skid_d_n_s;
   logic                  inflight_r;
   logic [1:0]            fill_s;
   logic                  accept_s;
   logic                  pop_s;

   // Words held plus the word in flight; never exceeds 2, so an arriving word
   // always finds a free slot.
   assign fill_s   = {1'b0, head_v_r} + {1'b0, skid_v_r} + {1'b0, inflight_r};
   assign accept_s = head_v_r & m_ready;

   // The path from m_ready to fifo_ren is combinational on purpose. Without it,
   // a full buffer would lose a cycle after backpressure releases.
   assign fifo_ren = ~fifo_empty & ((fill_s < 2'd2) | accept_s);
   assign pop_s    = fifo_ren & ~fifo_empty;

   assign m_valid  = head_v_r;
   assign m_data   = head_d_r;

   // Next-state routing of the head and skid entries for arrivals and accepts
   always_comb begin
      head_v_n_s = head_v_r;
      head_d_n_s = head_d_r;
      skid_v_n_s = skid_v_r;
      skid_d_n_s = skid_d_r;
      if (inflight_r) begin
         if (!head_v_r || (accept_s && !skid_v_r)) begin
            // head free, or free after this accept: word lands in the head
            head_v_n_s = 1'b1;
            head_d_n_s = fifo_rdata;
         end else if (accept_s) begin
            // head leaves, skid moves forward, new word refills the skid
            head_d_n_s = skid_d_r;
            skid_d_n_s = fifo_rdata;
         end else begin
            // head held: the word parks in the skid
            skid_v_n_s = 1'b1;
            skid_d_n_s = fifo_rdata;
         end
      end else if (accept_s) begin
         if (skid_v_r) begin
            head_d_n_s = skid_d_r;
            skid_v_n_s = 1'b0;
         end else begin
            head_v_n_s = 1'b0;
         end
      end else begin
         head_v_n_s = head_v_r;
      end
   end

   // Buffer and in-flight state registers
   always_ff @(posedge r_clk or negedge r_rstn) begin
      if (!r_rstn) begin
         head_v_r   <= 1'b0;
         head_d_r   <= {DATA_WIDTH{1'b0}};
         skid_v_r   <= 1'b0;
         skid_d_r   <= {DATA_WIDTH{1'b0}};
         inflight_r <= 1'b0;
      end else begin
         head_v_r   <= head_v_n_s;
         head_d_r   <= head_d_n_s;
         skid_v_r   <= skid_v_n_s;
         skid_d_r   <= skid_d_n_s;
         inflight_r <= pop_s;
      end
   end

`ifdef FIFO_RD_LEVEL_EN
   // Gray-to-binary conversion of a pointer
   function automatic logic [ADDR_WIDTH:0] gray2bin(input logic [ADDR_WIDTH:0] g);
      logic [ADDR_WIDTH:0] b;
      b[ADDR_WIDTH] = g[ADDR_WIDTH];
      for (int i = ADDR_WIDTH - 1; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

   logic [ADDR_WIDTH:0]   ptr_diff_s;
   logic [ADDR_WIDTH+1:0] level_n_s;

   // Pointer difference is taken modulo 2^(ADDR_WIDTH+1), so it wraps across
   // the pointer MSB without any special handling.
   assign ptr_diff_s = gray2bin(rq2_wptr) - gray2bin(rptr_gray);
   assign level_n_s  = {1'b0, ptr_diff_s} + {{ADDR_WIDTH{1'b0}}, fill_s};

   // Registered reader-visible level
   always_ff @(posedge r_clk or negedge r_rstn) begin
      if (!r_rstn) begin
         r_level <= {(ADDR_WIDTH+2){1'b0}};
      end else begin
         r_level <= level_n_s;
      end
   end
`endif

endmodule

// File: tb/tb_fifo_rd_fwft.sv
module tb_fifo_rd_fwft;

   logic       r_clk = 1'b0;
   logic       r_rstn;
   logic       fifo_empty;
   logic [7:0] fifo_rdata;
   logic       fifo_ren;
   logic       m_valid;
   logic       m_ready;
   logic [7:0] m_data;
`ifdef FIFO_RD_LEVEL_EN
   logic [4:0] rq2_wptr;
   logic [4:0] rptr_gray;
   logic [5:0] r_level;
`endif

   fifo_rd_fwft #(
      .DATA_WIDTH(8)
`ifdef FIFO_RD_LEVEL_EN
     ,.ADDR_WIDTH(4)
`endif
   ) dut (
      .r_clk      (r_clk),
      .r_rstn     (r_rstn),
      .fifo_empty (fifo_empty),
      .fifo_rdata (fifo_rdata),
      .fifo_ren   (fifo_ren),
      .m_valid    (m_valid),
      .m_ready    (m_ready),
      .m_data     (m_data)
`ifdef FIFO_RD_LEVEL_EN
     ,.rq2_wptr   (rq2_wptr),
      .rptr_gray  (rptr_gray),
      .r_level    (r_level)
`endif
   );

   always #5 r_clk = ~r_clk;

   // Reference model: words popped but not yet accepted, in pop order, each
   // tagged with the cycle of its pop. A word is visible two cycles after it.
   typedef struct {
      logic [7:0] d;
      int         pc;
   } ent_t;
   ent_t       q[$];
   int         cyc = 0;
   logic [7:0] src_word = 8'h00;
   bit         rand_mode = 1'b0;
   int         n_assert = 0;
   int         n_fail = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] req);
      n_assert++;
      assert (obs === req) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, req);
      end
   endtask

   // One clock cycle, entered and left at a falling edge.
   task automatic cycle(input logic empty, input logic rdy);
      logic       ev;
      logic [7:0] ed;
      logic       er;
      logic       acc;
      int         fill;
      fifo_empty = empty;
      m_ready    = rdy;
      #1;
      ev = (q.size() > 0) && (cyc >= q[0].pc + 2);
      ed = ev ? q[0].d : 8'h00;
      er = !empty && ((q.size() < 2) || (ev && rdy));
      check("m_valid", 32'(m_valid), 32'(ev));
      if (ev) check("m_data", 32'(m_data), 32'(ed));
      check("fifo_ren", 32'(fifo_ren), 32'(er));
      fill = int'(dut.head_v_r) + int'(dut.skid_v_r) + int'(dut.inflight_r);
      check("occ_inflight_le2", 32'(fill <= 2), 32'd1);
      acc = ev & rdy;
      @(posedge r_clk);
      if (acc) void'(q.pop_front());
      if (er) q.push_back('{d: src_word, pc: cyc});
      cyc++;
      @(negedge r_clk);
      if (er) begin
         fifo_rdata = src_word;
         src_word   = rand_mode ? 8'($urandom) : src_word + 8'd1;
      end else begin
         fifo_rdata = 8'($urandom);
      end
   endtask

   initial begin
      r_rstn     = 1'b0;
      fifo_empty = 1'b1;
      m_ready    = 1'b0;
      fifo_rdata = 8'h00;
`ifdef FIFO_RD_LEVEL_EN
      rq2_wptr   = 5'd0;
      rptr_gray  = 5'd0;
`endif
      @(negedge r_clk);
      @(negedge r_clk);
      #1;
      check("reset_m_valid", 32'(m_valid), 32'd0);
      check("reset_m_data", 32'(m_data), 32'd0);
      check("reset_fifo_ren", 32'(fifo_ren), 32'd0);
`ifdef FIFO_RD_LEVEL_EN
      check("reset_r_level", 32'(r_level), 32'd0);
`endif
      @(negedge r_clk);
      r_rstn = 1'b1;

      // single word 0xA5: visible two cycles after its pop, gone after accept
      src_word = 8'hA5;
      cycle(1'b0, 1'b1);
      for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1);

      // streaming 0x00..0x0F with m_ready high: no bubbles
      src_word = 8'h00;
      for (int i = 0; i < 16; i++) cycle(1'b0, 1'b1);
      for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1);

      // backpressure mid-stream for 5 cycles
      src_word = 8'h40;
      for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1);
      for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0);
      for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1);
      for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1);

      // random traffic
      rand_mode = 1'b1;
      src_word  = 8'($urandom);
      for (int i = 0; i < 5000; i++)
         cycle(1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 3) != 0));
      for (int i = 0; i < 5000; i++)
         cycle(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)));
      for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1);
      rand_mode = 1'b0;

      // reset mid-stream with head and skid full
      src_word = 8'h80;
      for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0);
      #2;
      r_rstn     = 1'b0;
      fifo_empty = 1'b1;
      #1;
      check("midrst_m_valid", 32'(m_valid), 32'd0);
      check("midrst_m_data", 32'(m_data), 32'd0);
      check("midrst_fifo_ren", 32'(fifo_ren), 32'd0);
      @(posedge r_clk);
      @(negedge r_clk);
      r_rstn = 1'b1;
      q.delete();
      for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1);
      src_word = 8'h5A;
      cycle(1'b0, 1'b1);
      for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1);

`ifdef FIFO_RD_LEVEL_EN
      // write pointer 3 ahead of a wrapped read pointer (bin 1 vs bin 30)
      rq2_wptr  = 5'd1;
      rptr_gray = 5'h11;
      cycle(1'b1, 1'b1);
      cycle(1'b1, 1'b1);
      check("r_level_wrap", 32'(r_level), 32'd3);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
